// File: rtl/if_stage_if.sv
// ============================================================================
// Module      : if_stage_if
// Description : Signal bundle for the instruction-fetch stage: the
//               instruction-memory request/grant/response channel and the
//               decode-facing instruction channel with stall/redirect.
//               master = fetch stage, slave = memory + decode/execute side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_stage_if;
    // Instruction-memory channel
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    // Pipeline control from decode / execute
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    // Instruction channel toward decode
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        input  stall,
        input  redirect,
        input  redirect_pc,
        output instr_valid,
        output instr,
        output pc,
        output pc_plus4
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        output stall,
        output redirect,
        output redirect_pc,
        input  instr_valid,
        input  instr,
        input  pc,
        input  pc_plus4
    );
endinterface

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module      : if_stage
// Description : RV32 instruction-fetch stage. Owns the fetch PC, issues word
//               requests to instruction memory (request/grant, in-order
//               responses), buffers returned words with their PCs in a small
//               FIFO and presents one instruction per cycle to decode.
//               Redirects flush the FIFO and discard in-flight responses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    if_stage_if.master bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int          c_PW        = $clog2(DEPTH);
    localparam int          c_CW        = $clog2(DEPTH) + 1;
    localparam logic [31:0] c_NOP       = 32'h0000_0013;
    localparam logic [31:0] c_WORD      = 32'h0000_0004;
    localparam logic [31:0] c_ALIGN     = 32'hFFFF_FFFC;
    // One extra bit so the occupancy sum can never wrap before comparison
    localparam logic [c_CW:0] c_DEPTH_EXT = (c_CW + 1)'(DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [31:0]      r_fetch_pc;     // address of the next request to issue
    logic [31:0]      r_resp_pc;      // PC that the next kept response belongs to
    logic [c_CW-1:0]  r_count;        // FIFO occupancy
    logic [c_CW-1:0]  r_outst;        // granted requests not yet answered
    logic [c_CW-1:0]  r_discard;      // of those, how many belong to a flushed path
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_PW-1:0]  r_wr_ptr;
    logic [31:0]      r_fifo_pc   [DEPTH];
    logic [31:0]      r_fifo_word [DEPTH];

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic             w_redirect;
    logic [31:0]      w_redirect_pc;
    logic             w_valid;
    logic             w_pop;
    logic             w_rsp;
    logic             w_drop;
    logic             w_push;
    logic [c_CW:0]    w_occ;
    logic             w_req;
    logic             w_issue;

    // Redirect only has meaning while out of reset
    assign w_redirect    = rst_n & bus.redirect;
    assign w_redirect_pc = bus.redirect_pc & c_ALIGN;

    // Head is visible unless the FIFO is empty or the path is being flushed
    assign w_valid = rst_n & ~bus.redirect & (r_count != '0);
    assign w_pop   = w_valid & ~bus.stall;

    // A response with nothing outstanding is a protocol violation and ignored
    assign w_rsp   = rst_n & bus.imem_rvalid & (r_outst != '0);
    assign w_drop  = w_rsp & (r_discard != '0);
    assign w_push  = w_rsp & ~w_drop & ~bus.redirect;

    // Every outstanding request owns a FIFO slot, so a push can never find
    // the FIFO full; a slot freed by this cycle's pop may be reused at once.
    assign w_occ   = {1'b0, r_count} + {1'b0, r_outst} - {{c_CW{1'b0}}, w_pop};
    assign w_req   = rst_n & ~bus.redirect & (w_occ < c_DEPTH_EXT);
    assign w_issue = w_req & bus.imem_gnt;

    // ------------------------------------------------------------------------
    // Fetch PC: advances on every granted request, reloads on redirect
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
        end else if (w_redirect) begin
            r_fetch_pc <= w_redirect_pc;
        end else if (w_issue) begin
            r_fetch_pc <= r_fetch_pc + c_WORD;
        end
    end

    // ------------------------------------------------------------------------
    // Response PC: tags each kept response, tracks the fetch PC in grant order
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_resp_pc <= RESET_PC;
        end else if (w_redirect) begin
            r_resp_pc <= w_redirect_pc;
        end else if (w_push) begin
            r_resp_pc <= r_resp_pc + c_WORD;
        end
    end

    // ------------------------------------------------------------------------
    // Occupancy, outstanding and discard bookkeeping
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_outst   <= '0;
            r_discard <= '0;
        end else if (w_redirect) begin
            // Every request still in flight after this cycle belongs to the
            // abandoned path; r_outst already includes any earlier discards,
            // so the new discard count is simply what remains outstanding.
            r_count   <= '0;
            r_outst   <= r_outst - c_CW'(w_rsp);
            r_discard <= r_outst - c_CW'(w_rsp);
        end else begin
            r_count   <= r_count + c_CW'(w_push) - c_CW'(w_pop);
            r_outst   <= r_outst + c_CW'(w_issue) - c_CW'(w_rsp);
            if (w_drop) begin
                r_discard <= r_discard - c_CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // FIFO read/write pointers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (w_redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // FIFO storage: written on push, contents qualified by r_count
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_resp_pc;
            r_fifo_word[r_wr_ptr] <= bus.imem_rdata;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs toward memory and decode; head of FIFO is read combinationally
    // ------------------------------------------------------------------------
    always_comb begin
        bus.imem_req    = w_req;
        bus.imem_addr   = r_fetch_pc;
        bus.instr_valid = w_valid;
        bus.instr       = c_NOP;
        bus.pc          = 32'h0000_0000;
        if (w_valid) begin
            bus.instr = r_fifo_word[r_rd_ptr];
            bus.pc    = r_fifo_pc[r_rd_ptr];
        end
        bus.pc_plus4    = bus.pc + c_WORD;
    end

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module      : tb_if_stage
// Description : Self-checking bench for if_stage. A queue-based reference
//               model (expected FIFO contents, in-flight requests tagged
//               live/stale) is compared against the DUT every cycle, with
//               directed scenarios pinned by hand-computed literals followed
//               by a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n;

    if_stage_if bus ();

    if_stage #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] word; } entry_t;
    typedef struct { logic [31:0] addr; bit live; }        flight_t;
    typedef struct { logic [31:0] addr; int due; }         pend_t;

    entry_t  mq[$];     // what decode should see, in order
    flight_t fl[$];     // requests granted, awaiting response
    pend_t   pend[$];   // memory model: scheduled responses
    logic [31:0] m_fetch;
    int cyc;
    int last_due;
    int n_cmp;
    int n_err;

    // Per-cycle stimulus knobs
    bit          drv_rst_n;
    bit          drv_stall;
    bit          drv_redirect;
    logic [31:0] drv_rpc;
    bit          drv_gnt;
    bit          drv_stray;
    int          k_lat;      // 0 = random 1..3, else fixed latency
    bit          r_now;
    bit          e_valid;
    bit          e_pop;
    bit          e_req;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Apply this cycle's inputs, let logic settle, compare against model
    task automatic drive_and_check();
        logic [31:0] ep;
        logic [31:0] ew;
        int          occ;
        @(negedge clk);
        rst_n           = drv_rst_n;
        bus.stall       = drv_stall;
        bus.redirect    = drv_redirect;
        bus.redirect_pc = drv_rpc;
        bus.imem_gnt    = drv_gnt;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        if (drv_rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = memw(pend[0].addr);
            void'(pend.pop_front());
        end else if (drv_rst_n && drv_stray && pend.size() == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 32'hDEAD_BEEF;
        end
        r_now = bus.imem_rvalid;
        #1;
        e_valid = drv_rst_n && !drv_redirect && (mq.size() != 0);
        e_pop   = e_valid && !drv_stall;
        occ     = mq.size() + fl.size() - (e_pop ? 1 : 0);
        e_req   = drv_rst_n && !drv_redirect && (occ < DEPTH);
        ep = 32'h0;
        ew = NOP;
        if (e_valid) begin
            ep = mq[0].pc;
            ew = mq[0].word;
        end
        chk("instr_valid", {31'b0, bus.instr_valid}, {31'b0, e_valid});
        chk("imem_req",    {31'b0, bus.imem_req},    {31'b0, e_req});
        if (e_req) chk("imem_addr", bus.imem_addr, m_fetch);
        chk("instr",    bus.instr,    ew);
        chk("pc",       bus.pc,       ep);
        chk("pc_plus4", bus.pc_plus4, ep + 32'd4);
    endtask

    // Advance model and memory to the next cycle
    task automatic commit();
        flight_t f;
        int      lat;
        int      due;
        if (!drv_rst_n) begin
            mq.delete();
            fl.delete();
            pend.delete();
            m_fetch  = RESET_PC;
            last_due = -1;
        end else begin
            if (e_pop) void'(mq.pop_front());
            if (r_now && fl.size() > 0) begin
                f = fl.pop_front();
                if (f.live && !drv_redirect) mq.push_back('{pc: f.addr, word: memw(f.addr)});
            end
            if (drv_redirect) begin
                mq.delete();
                foreach (fl[i]) fl[i].live = 1'b0;
                m_fetch = drv_rpc & 32'hFFFF_FFFC;
            end else if (e_req && drv_gnt) begin
                fl.push_back('{addr: m_fetch, live: 1'b1});
                m_fetch = m_fetch + 32'd4;
            end
            if (bus.imem_req && drv_gnt) begin
                lat = (k_lat == 0) ? int'($urandom_range(3, 1)) : k_lat;
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend.push_back('{addr: bus.imem_addr, due: due});
            end
        end
        cyc++;
    endtask

    task automatic step();
        drive_and_check();
        commit();
    endtask

    // Run until the first valid instruction and pin its PC and word
    task automatic expect_first(input string name, input logic [31:0] exp_pc, input int bound);
        bit found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            drive_and_check();
            if (bus.instr_valid) begin
                chk(name, bus.pc, exp_pc);
                chk({name, "_word"}, bus.instr, memw(exp_pc));
                found = 1'b1;
            end
            commit();
            drv_redirect = 1'b0;
            drv_stray    = 1'b0;
        end
        if (!found) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: no valid instruction within %0d cycles, expected pc %h", name, bound, exp_pc);
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; last_due = -1; m_fetch = RESET_PC;
        drv_rst_n = 1'b0; drv_stall = 1'b0; drv_redirect = 1'b0; drv_rpc = 32'h0;
        drv_gnt = 1'b1; drv_stray = 1'b0; k_lat = 1;

        // Reset: outputs idle
        repeat (3) begin
            drive_and_check();
            chk("rst_req",   {31'b0, bus.imem_req}, 32'd0);
            chk("rst_instr", bus.instr, 32'h0000_0013);
            chk("rst_pc4",   bus.pc_plus4, 32'h4);
            commit();
        end

        // Stream with a stall window in cycles 3..6
        drv_rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            drv_stall = (c >= 3 && c <= 6);
            drive_and_check();
            case (c)
                0: begin chk("c0_req", {31'b0, bus.imem_req}, 32'd1); chk("c0_addr", bus.imem_addr, 32'h0); end
                1: chk("c1_addr", bus.imem_addr, 32'h4);
                2: begin chk("c2_valid", {31'b0, bus.instr_valid}, 32'd1); chk("c2_pc", bus.pc, 32'h0);
                         chk("c2_instr", bus.instr, 32'h00C0_FFEE); end
                3: chk("c3_pc", bus.pc, 32'h4);
                6: begin chk("c6_pc", bus.pc, 32'h4); chk("c6_req", {31'b0, bus.imem_req}, 32'd0); end
                7: chk("c7_pc", bus.pc, 32'h4);
                8: chk("c8_pc", bus.pc, 32'h8);
                9: chk("c9_pc", bus.pc, 32'hC);
                default: ;
            endcase
            commit();
        end
        drv_stall = 1'b0;

        // Redirect with 1-cycle memory to an unaligned target
        drv_redirect = 1'b1; drv_rpc = 32'h0000_0103;
        drive_and_check();
        chk("rd_valid", {31'b0, bus.instr_valid}, 32'd0);
        commit();
        drv_redirect = 1'b0;
        drive_and_check();
        chk("rd_addr", bus.imem_addr, 32'h100);
        commit();
        expect_first("rd_first", 32'h100, 8);

        // Redirect with two requests in flight (2-cycle memory)
        k_lat = 2;
        repeat (6) step();
        drv_redirect = 1'b1; drv_rpc = 32'h0000_0200;
        expect_first("rd2_first", 32'h200, 12);

        // Grant backpressure: addr 0x8 held while gnt is low
        k_lat = 1;
        repeat (4) step();
        drv_redirect = 1'b1; drv_rpc = 32'h0;
        step();
        drv_redirect = 1'b0;
        step();
        step();
        drv_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_and_check();
            chk("bp_req",  {31'b0, bus.imem_req}, 32'd1);
            chk("bp_addr", bus.imem_addr, 32'h8);
            commit();
        end
        drv_gnt = 1'b1;
        drive_and_check();
        chk("bp_resume", bus.imem_addr, 32'h8);
        commit();
        step();
        drive_and_check();
        chk("bp_pc8", bus.pc, 32'h8);
        commit();

        // Fill under stall, then redirect + stall + stray response together
        drv_stall = 1'b1;
        repeat (5) step();
        drv_redirect = 1'b1; drv_rpc = 32'h0000_0400; drv_stray = 1'b1;
        step();
        drv_redirect = 1'b0; drv_stray = 1'b0;
        drive_and_check();
        chk("rsr_valid", {31'b0, bus.instr_valid}, 32'd0);
        commit();
        drv_stall = 1'b0;
        expect_first("rsr_first", 32'h400, 8);

        // Reset mid-stream with FIFO full
        drv_stall = 1'b1;
        repeat (5) step();
        drv_rst_n = 1'b0;
        drive_and_check();
        chk("mr_valid", {31'b0, bus.instr_valid}, 32'd0);
        chk("mr_instr", bus.instr, 32'h0000_0013);
        chk("mr_req",   {31'b0, bus.imem_req}, 32'd0);
        commit();
        drv_rst_n = 1'b1; drv_stall = 1'b0;
        drive_and_check();
        chk("mr_valid2", {31'b0, bus.instr_valid}, 32'd0);
        chk("mr_addr",   bus.imem_addr, RESET_PC);
        commit();

        // Wrap-around at the top of the address space
        drv_redirect = 1'b1; drv_rpc = 32'hFFFF_FFFE;
        expect_first("wrap_first", 32'hFFFF_FFFC, 8);
        expect_first("wrap_next",  32'h0000_0000, 8);

        // Randomized phase
        k_lat = 0;
        for (int i = 0; i < 4000; i++) begin
            drv_rst_n    = ($urandom_range(99) >= 1);
            drv_gnt      = ($urandom_range(99) < 70);
            drv_stall    = ($urandom_range(99) < 30);
            drv_redirect = ($urandom_range(99) < 4);
            drv_stray    = ($urandom_range(99) < 2);
            drv_rpc      = $urandom;
            if ($urandom_range(7) == 0) drv_rpc = 32'hFFFF_FFF0 | {28'h0, 4'($urandom_range(15))};
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
